serial_pattern_gen: RTL
=======================

Name: serial_pattern_gen

Overview:
- Transmit-side counterpart of the team's "01" sequence detector FSM.
- Serialises a loaded bit pattern, MSB first, onto a one-bit stream `a`. The stream advances only on cycles where `en` is high, so the detector can be driven bit-for-bit in the same `en` domain.
- Also provides a free-running PRBS7 mode for soak testing the detector.
- Sits between the stimulus/control logic and the detector's `a`/`en` inputs.

Parameters:
- W, 8, width of the pattern word (2..32).
- LW, $clog2(W+1), width of `load_len`.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  bit-advance strobe; the serial state changes only when en=1.
- load_valid  input  1  a load request is present.
- load_ready  output  1  the block can accept a load (high only in IDLE).
- load_data  input  W  pattern to send, MSB first.
- load_len  input  LW  number of bits to send; 0 and values > W mean W.
- load_mode  input  1  0 = pattern word, 1 = PRBS7.
- load_repeat  input  1  1 = resend the same word continuously until `stop`.
- stop  input  1  ends SEND or PRBS at the next bit boundary.
- a  output  1  serial bit.
- a_valid  output  1  `a` carries a meaningful bit (state SEND or PRBS).
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse when a transmission ends.

Behaviour:
- Reset (async, active-high) forces:
  - state=IDLE;
  - shift register, bit counter and stored word to 0;
  - LFSR to 7'h01;
  - a=0, a_valid=0, busy=0, done=0, load_ready=1.
- States and transitions:
  - IDLE:
    - load_ready=1, a=0, a_valid=0.
    - Accept on load_valid & load_ready, independent of en.
    - On accept with load_mode=0: capture data, len and repeat; state goes to SEND next cycle.
    - On accept with load_mode=1: state goes to PRBS next cycle and the LFSR is reseeded to 7'h01.
  - SEND:
    - a = shreg[W-1] from the first SEND cycle (latency 1 clk from accept).
    - On each cycle with en=1: shreg shifts left by 1 and cnt decrements.
    - On the last bit (cnt==1 & en):
      - if repeat=1 and stop=0: reload shreg from the stored word and cnt from the stored len, stay in SEND, no done pulse;
      - otherwise: go to IDLE and pulse done on that same edge's following cycle.
    - stop=1 together with en=1 on any bit: that bit completes, then IDLE with done=1. stop with en=0 is ignored.
  - PRBS:
    - a = lfsr[6].
    - On each cycle with en=1: lfsr <= {lfsr[5:0], lfsr[6]^lfsr[5]} (x^7+x^6+1, period 127).
    - stop & en: go to IDLE with done=1.
- Hold rule: with en=0, a, state, cnt and lfsr all hold; done is never asserted for more than 1 cycle.
- load_valid while busy is ignored (load_ready=0); there is no queueing.
- done is registered. It is high for exactly the first IDLE cycle after SEND/PRBS, and load_ready is already 1 in that cycle.
- Reset mid-operation aborts immediately to the reset values, with no done pulse.
- Length mapping: effective len = (load_len==0 || load_len>W) ? W : load_len. A 1-bit send finishes after 1 en strobe.

Test Plan:
- Pattern "01" to detector: W=8, load_data=8'h40, len=2, mode=0, en every cycle → a=0 then a=1; detector y=1 one cycle after the second bit; done pulse 1 cycle later; load_ready back to 1.
- Gated enable: same load with en high on every 3rd cycle → each bit held exactly 3 clk; total busy = 6 clk; done a single 1-cycle pulse.
- Repeat and stop: load_data=8'hA5, len=8, repeat=1, en=1 → stream 10100101 repeats ≥3 times; assert stop during bit 4 of pass 3 → bit 4 completes, then IDLE, done=1.
- Length edge cases: len=0 → exactly 8 bits sent; len=1 with data MSB=1 → one bit '1', done after 1 en strobe; len=9 with W=8 → 8 bits sent.
- PRBS: mode=1, en=1 for 254 cycles → first 7 bits 0000001 (a = lfsr[6] from seed 7'h01); sequence repeats with period 127; stop → IDLE and done.
- Async reset and ignored load: assert reset between clock edges mid-SEND → a, a_valid, busy drop without waiting for a clock edge, no done; load_valid while busy → no change in stream.

Source files
------------

// File: rtl/serial_pattern_gen.sv
// Serial pattern / PRBS7 source feeding the "01" detector's a/en inputs.
// Bits advance only on en strobes; done pulses in the first IDLE cycle after a transmission.
module serial_pattern_gen #(
  parameter int W  = 8,
  parameter int LW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [W-1:0]  load_data,
  input  logic [LW-1:0] load_len,
  input  logic          load_mode,
  input  logic          load_repeat,
  input  logic          stop,
  output logic          a,
  output logic          a_valid,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, SEND, PRBS} state_t;

  localparam logic [LW-1:0] FULL_LEN = LW'(W);
  localparam logic [LW-1:0] ONE_LEN  = LW'(1);
  localparam logic [6:0]    LFSR_SEED = 7'h01;

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_shreg;
  logic [W-1:0]  r_word;
  logic [LW-1:0] r_cnt;
  logic [LW-1:0] r_len;
  logic          r_repeat;
  logic [6:0]    r_lfsr;
  logic          r_done;
  logic          w_accept;
  logic          w_lastBit;
  logic [LW-1:0] w_effLen;

  assign w_accept  = load_valid && (r_state == IDLE);
  assign w_lastBit = (r_cnt == ONE_LEN);
  // Zero or oversize lengths fall back to the full word.
  assign w_effLen  = ((load_len == '0) || (load_len > FULL_LEN)) ? FULL_LEN : load_len;
  assign done      = r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = load_mode ? PRBS : SEND;
      SEND:    if (en && (stop || (w_lastBit && !r_repeat))) w_next = IDLE;
      PRBS:    if (en && stop) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    a          = 1'b0;
    a_valid    = 1'b0;
    busy       = 1'b1;
    case (r_state)
      IDLE: begin
        load_ready = 1'b1;
        busy       = 1'b0;
      end
      SEND: begin
        a       = r_shreg[W-1];
        a_valid = 1'b1;
      end
      PRBS: begin
        a       = r_lfsr[6];
        a_valid = 1'b1;
      end
      default: begin
        load_ready = 1'b0;
        busy       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shreg  <= '0;
      r_word   <= '0;
      r_cnt    <= '0;
      r_len    <= '0;
      r_repeat <= 1'b0;
      r_lfsr   <= LFSR_SEED;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state != IDLE) && (w_next == IDLE);
      case (r_state)
        IDLE: begin
          if (w_accept && !load_mode) begin
            r_shreg  <= load_data;
            r_word   <= load_data;
            r_cnt    <= w_effLen;
            r_len    <= w_effLen;
            r_repeat <= load_repeat;
          end else if (w_accept) begin
            r_lfsr <= LFSR_SEED;
          end
        end
        SEND: begin
          // Repeat mode reloads on the last bit unless a stop arrives with it.
          if (en && w_lastBit && r_repeat && !stop) begin
            r_shreg <= r_word;
            r_cnt   <= r_len;
          end else if (en) begin
            r_shreg <= {r_shreg[W-2:0], 1'b0};
            r_cnt   <= r_cnt - ONE_LEN;
          end
        end
        PRBS: begin
          if (en) r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
        end
        default: r_lfsr <= r_lfsr;
      endcase
    end
  end

endmodule
